// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared width default, FSM state and word type for the NTT blocks
package ntt_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BF    = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [W_DEF-1:0] word_t;

endpackage

// File: rtl/gs_butterfly.sv
// rtl/gs_butterfly.sv - combinational Gentleman-Sande butterfly holding the one modular multiplier
module gs_butterfly
    import ntt_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] w,
    input  logic [W-1:0] q,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out
);

    logic [W:0]     sum;
    logic [W-1:0]   diff;
    logic [2*W-1:0] prod;

    // a and b are already < q, so a single conditional subtract/add reduces them
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        a_out = (sum >= {1'b0, q}) ? W'(sum - {1'b0, q}) : W'(sum);
        diff  = (a >= b) ? (a - b) : W'({1'b0, a} + {1'b0, q} - {1'b0, b});
        prod  = {{W{1'b0}}, diff} * {{W{1'b0}}, w};
        b_out = W'(prod % {{W{1'b0}}, q});
    end

endmodule

// File: rtl/intt_4point_seq.sv
// rtl/intt_4point_seq.sv - sequential 4-point inverse NTT: four GS butterflies then four n_inv scalings
module intt_4point_seq
    import ntt_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0][W-1:0]  data_in,
    input  logic [1:0][W-1:0]  omegas_inv,
    input  logic [W-1:0]       n_inv,
    input  logic [W-1:0]       mod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0][W-1:0]  data_out,
    output logic               busy
);

    state_t            state, state_nx;
    logic [1:0]        idx, idx_nx;
    logic [3:0][W-1:0] work;
    logic [1:0][W-1:0] w_reg;
    logic [W-1:0]      ninv_reg;
    logic [W-1:0]      q_reg;

    logic              accept;
    logic [1:0]        ia, ib;
    logic [W-1:0]      bf_a, bf_b, bf_w;
    logic [W-1:0]      res_a, res_b;

    assign accept    = in_valid && (state == IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign data_out  = work;

    // Stage-2 pairs are undone first, then stage-1; SCALE reuses the b-path with b=0
    always_comb begin
        ia   = 2'd0;
        ib   = 2'd2;
        bf_w = w_reg[0];
        case (idx)
            2'd0: begin ia = 2'd0; ib = 2'd2; end
            2'd1: begin ia = 2'd1; ib = 2'd3; bf_w = w_reg[1]; end
            2'd2: begin ia = 2'd0; ib = 2'd1; end
            default: begin ia = 2'd2; ib = 2'd3; end
        endcase
        bf_a = work[ia];
        bf_b = work[ib];
        if (state == SCALE) begin
            bf_a = work[idx];
            bf_b = '0;
            bf_w = ninv_reg;
        end
    end

    gs_butterfly #(.W(W)) u_bf (
        .a     (bf_a),
        .b     (bf_b),
        .w     (bf_w),
        .q     (q_reg),
        .a_out (res_a),
        .b_out (res_b)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = BF;
                    idx_nx   = 2'd0;
                end
            end
            BF: begin
                idx_nx = idx + 2'd1;
                if (idx == 2'd3) state_nx = SCALE;
            end
            SCALE: begin
                idx_nx = idx + 2'd1;
                if (idx == 2'd3) state_nx = DONE;
            end
            default: begin
                if (out_ready) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            work     <= '0;
            w_reg    <= '0;
            ninv_reg <= '0;
            q_reg    <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (accept) begin
                for (int i = 0; i < 4; i++) work[i] <= data_in[i] % mod;
                w_reg    <= omegas_inv;
                ninv_reg <= n_inv;
                q_reg    <= mod;
            end else if (state == BF) begin
                work[ia] <= res_a;
                work[ib] <= res_b;
            end else if (state == SCALE) begin
                work[idx] <= res_b;
            end
        end
    end

endmodule

// File: tb/tb_intt_4point_seq.sv
// tb/tb_intt_4point_seq.sv - randomized round-trip bench for intt_4point_seq with a behavioural model
module tb_intt_4point_seq;

    localparam int W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0][W-1:0] data_in;
    logic [1:0][W-1:0] omegas_inv;
    logic [W-1:0]      n_inv;
    logic [W-1:0]      mod;
    logic              out_valid;
    logic              out_ready;
    logic [3:0][W-1:0] data_out;
    logic              busy;

    int errors = 0;
    int checks = 0;

    int exp_data[4];
    int cur_q = 2;
    bit exp_pending = 0;

    intt_4point_seq #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .omegas_inv (omegas_inv),
        .n_inv      (n_inv),
        .mod        (mod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int modinv(input int a, input int q);
        for (int i = 1; i < q; i++)
            if (((a * i) % q) == 1) return i;
        return 0;
    endfunction

    // Forward CT network: stage 1 (0,1),(2,3) with w0; stage 2 (0,2) w0, (1,3) w1
    function automatic void fwd(input int x[4], input int w0, input int w1, input int q, output int y[4]);
        int t[4];
        int p;
        p = (w0 * x[1]) % q; t[0] = (x[0] + p) % q; t[1] = (x[0] - p + q) % q;
        p = (w0 * x[3]) % q; t[2] = (x[2] + p) % q; t[3] = (x[2] - p + q) % q;
        p = (w0 * t[2]) % q; y[0] = (t[0] + p) % q; y[2] = (t[0] - p + q) % q;
        p = (w1 * t[3]) % q; y[1] = (t[1] + p) % q; y[3] = (t[1] - p + q) % q;
    endfunction

    function automatic void model_intt(input int x[4], input int wi0, input int wi1, input int ni,
                                       input int q, output int y[4]);
        int a[4];
        int pi[4] = '{0, 1, 0, 2};
        int pj[4] = '{2, 3, 1, 3};
        int s;
        int d;
        int w;
        for (int k = 0; k < 4; k++) a[k] = x[k] % q;
        for (int k = 0; k < 4; k++) begin
            w = (k == 1) ? wi1 : wi0;
            s = (a[pi[k]] + a[pj[k]]) % q;
            d = (((a[pi[k]] - a[pj[k]] + q) % q) * w) % q;
            a[pi[k]] = s;
            a[pj[k]] = d;
        end
        for (int k = 0; k < 4; k++) y[k] = (a[k] * ni) % q;
    endfunction

    // Single compare process: every cycle the result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_pending) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("data_out[%0d]", i), data_out[i], exp_data[i]);
                    check($sformatf("lt_q[%0d]", i), (int'(data_out[i]) < cur_q) ? 1 : 0, 1);
                end
            end
        end
    end

    task automatic run_frame(input int d[4], input int wi0, input int wi1, input int ni, input int q,
                             input int hold, input bit toggle);
        int k;
        int e[4];
        model_intt(d, wi0, wi1, ni, q, e);
        exp_data    = e;
        cur_q       = q;
        exp_pending = 1;
        check("in_ready_idle", in_ready, 1);
        for (int i = 0; i < 4; i++) data_in[i] = W'(d[i]);
        omegas_inv[0] = W'(wi0);
        omegas_inv[1] = W'(wi1);
        n_inv         = W'(ni);
        mod           = W'(q);
        in_valid      = 1'b1;
        out_ready     = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            if (toggle) begin
                data_in    = 32'($urandom);
                omegas_inv = 16'($urandom);
                n_inv      = 8'($urandom);
                mod        = 8'($urandom_range(255, 2));
                in_valid   = 1'($urandom);
            end
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        check("latency_edges", k, 8);
        for (int h = 0; h < hold; h++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_busy", busy, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        exp_pending = 0;
    endtask

    initial begin
        int d[4];
        int x[4];
        int y[4];
        int e[4];
        int q;
        int w0;
        int w1;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        data_in    = '0;
        omegas_inv = '0;
        n_inv      = '0;
        mod        = 8'd17;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed anchors for the model (q=17, inverse twiddles 13 and 4, n_inv 13)
        d = '{4, 13, 4, 13};
        model_intt(d, 13, 4, 13, 17, e);
        check("model_pin_e0", e[0], 0);
        check("model_pin_e1", e[1], 1);
        check("model_pin_e2", e[2], 0);
        check("model_pin_e3", e[3], 0);
        d = '{1, 1, 1, 1};
        model_intt(d, 13, 4, 13, 17, e);
        check("model_pin_dc", e[0] * 1000 + e[1] * 100 + e[2] * 10 + e[3], 1000);

        d = '{1, 1, 1, 1};
        run_frame(d, 13, 4, 13, 17, 0, 0);
        d = '{4, 13, 4, 13};
        run_frame(d, 13, 4, 13, 17, 0, 0);
        d = '{0, 0, 0, 0};
        run_frame(d, 13, 4, 13, 17, 0, 0);
        d = '{18, 30, 21, 13};
        run_frame(d, 13, 4, 13, 17, 5, 0);

        // Reset while the third butterfly is pending
        d = '{1, 1, 1, 1};
        for (int i = 0; i < 4; i++) data_in[i] = W'(d[i]);
        omegas_inv[0] = 8'd13;
        omegas_inv[1] = 8'd4;
        n_inv         = 8'd13;
        mod           = 8'd17;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_reset", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(d, 13, 4, 13, 17, 0, 0);

        // Random round trips: forward model output through the DUT must give the input back
        for (int n = 0; n < 16; n++) begin
            q  = (n % 2 == 1) ? 97 : 17;
            w0 = $urandom_range(q - 1, 1);
            w1 = $urandom_range(q - 1, 1);
            for (int i = 0; i < 4; i++) x[i] = $urandom_range(q - 1, 0);
            fwd(x, w0, w1, q, y);
            model_intt(y, modinv(w0, q), modinv(w1, q), modinv(4, q), q, e);
            for (int i = 0; i < 4; i++) check($sformatf("model_roundtrip[%0d]", i), e[i], x[i]);
            if (q == 17)
                for (int i = 0; i < 4; i++) y[i] = y[i] + 17 * $urandom_range(13, 0);
            run_frame(y, modinv(w0, q), modinv(w1, q), modinv(4, q), q, n % 3, (n % 4) >= 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
